// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, ALU operations and instruction field positions for exec_core
package exec_pkg;
  localparam int W = 8;
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;
  localparam logic [7:0] OP_LWD   = 8'h09;
  localparam logic [7:0] OP_LWI   = 8'h0A;
  localparam logic [7:0] OP_SWD   = 8'h0B;
  localparam logic [7:0] OP_SWI   = 8'h0C;
  localparam logic [7:0] OP_MULT  = 8'h0D;
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam int OP_MSB = 31, OP_LSB = 24;
  localparam int OFF_MSB = 23, OFF_LSB = 16;
  localparam int DST_MSB = 18, DST_LSB = 16;
  localparam int SRC1_MSB = 10, SRC1_LSB = 8;
  localparam int SRC2_MSB = 2, SRC2_LSB = 0;
  localparam int IMM_MSB = 7, IMM_LSB = 0;
endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational 8-bit ALU; multiply only when EXEC_MULT_EN is defined
module exec_alu import exec_pkg::*; (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   ALUOP,
  output logic [W-1:0] RESULT,
  output logic         ZERO
);
  logic [W-1:0] mul;
`ifdef EXEC_MULT_EN
  assign mul = W'(A * B);
`else
  assign mul = '0;
`endif
  always_comb begin
    RESULT = ALUOP == ALU_FWD ? B :
             ALUOP == ALU_ADD ? A + B :
             ALUOP == ALU_AND ? A & B :
             ALUOP == ALU_OR  ? A | B :
             ALUOP == ALU_MUL ? mul : '0;
    ZERO = RESULT == '0;
  end
endmodule

// File: rtl/exec_core.sv
// exec_core: single-cycle decode, operand select, ALU and PC with relative branches.
// Define EXEC_MULT_EN to enable the mult opcode.
module exec_core import exec_pkg::*; (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        INSTRUCTION,
  input  logic [W-1:0]       OUT1,
  input  logic [W-1:0]       OUT2,
  input  logic               BUSYWAIT,
  output logic [2:0]         RD_ADDR1,
  output logic [2:0]         RD_ADDR2,
  output logic [2:0]         WR_ADDR,
  output logic               REG_WRITE,
  output logic               WB_SEL,
  output logic               READEN,
  output logic               WRITEEN,
  output logic [W-1:0]       ALU_RESULT,
  output logic               ZERO,
  output logic signed [31:0] PC
);
  logic [7:0] op;
  logic [W-1:0] imm, b;
  logic [2:0] aluop;
  logic is_mult, use_imm, negate, wr, take, unused_bits;
  logic signed [31:0] pc4, offset;
  assign op = INSTRUCTION[OP_MSB:OP_LSB];
  assign imm = INSTRUCTION[IMM_MSB:IMM_LSB];
  assign unused_bits = ^INSTRUCTION[15:11];
  assign RD_ADDR1 = INSTRUCTION[SRC1_MSB:SRC1_LSB];
  assign RD_ADDR2 = INSTRUCTION[SRC2_MSB:SRC2_LSB];
  assign WR_ADDR = INSTRUCTION[DST_MSB:DST_LSB];
`ifdef EXEC_MULT_EN
  assign is_mult = op == OP_MULT;
`else
  assign is_mult = 1'b0;
`endif
  always_comb begin
    use_imm = op == OP_LOADI || op == OP_LWI || op == OP_SWI;
    negate = op == OP_SUB || op == OP_BEQ || op == OP_BNE;
    b = negate ? ~OUT2 + 1'b1 : use_imm ? imm : OUT2;
    aluop = (op == OP_ADD || negate) ? ALU_ADD :
            op == OP_AND ? ALU_AND :
            op == OP_OR  ? ALU_OR  :
            is_mult      ? ALU_MUL : ALU_FWD;
    wr = op == OP_LOADI || op == OP_MOV || op == OP_ADD || op == OP_SUB || op == OP_AND ||
         op == OP_OR || op == OP_LWD || op == OP_LWI || is_mult;
    REG_WRITE = wr && !BUSYWAIT;
    WB_SEL = op == OP_LWD || op == OP_LWI;
    READEN = op == OP_LWD || op == OP_LWI;
    WRITEEN = op == OP_SWD || op == OP_SWI;
    take = op == OP_J || (op == OP_BEQ && ZERO) || (op == OP_BNE && !ZERO);
    pc4 = PC + 32'sd4;
    offset = {{22{INSTRUCTION[OFF_MSB]}}, INSTRUCTION[OFF_MSB:OFF_LSB], 2'b00};
  end
  exec_alu u_alu (.A(OUT1), .B(b), .ALUOP(aluop), .RESULT(ALU_RESULT), .ZERO(ZERO));
  // A taken branch wins over a stall; a stall only freezes sequential fetch
  always_ff @(posedge CLK) begin
    if (RESET) PC <= '0;
    else if (take) PC <= pc4 + offset;
    else if (!BUSYWAIT) PC <= pc4;
  end
endmodule

// File: tb/tb_exec_core.sv
// tb_exec_core: vector table for decode/ALU plus hand sequences for branches, stalls and reset
module tb_exec_core;
  logic CLK = 0, RESET, BUSYWAIT, REG_WRITE, WB_SEL, READEN, WRITEEN, ZERO;
  logic [31:0] INSTRUCTION, PC;
  logic [7:0] OUT1, OUT2, ALU_RESULT;
  logic [2:0] RD_ADDR1, RD_ADDR2, WR_ADDR;
  int checks = 0, fails = 0;
  logic [31:0] model_pc = 0;
  logic [31:0] exp_q[$];

  exec_core dut (.CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .OUT1(OUT1), .OUT2(OUT2),
    .BUSYWAIT(BUSYWAIT), .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2), .WR_ADDR(WR_ADDR),
    .REG_WRITE(REG_WRITE), .WB_SEL(WB_SEL), .READEN(READEN), .WRITEEN(WRITEEN),
    .ALU_RESULT(ALU_RESULT), .ZERO(ZERO), .PC(PC));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] op, hi, lo, a, b, res;
    logic alu_ok, z, rw, wb, rd, wr;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] hi,
                                      input logic [2:0] s1, input logic [7:0] lo);
    return {op, hi, 5'b0, s1, lo};
  endfunction

  task automatic clk_step(input logic take);
    logic [31:0] off, exp;
    off = {{22{INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
    exp = RESET ? 32'h0 : take ? model_pc + 4 + off : BUSYWAIT ? model_pc : model_pc + 4;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    model_pc = exp_q.pop_front();
    chk("pc", PC, model_pc);
  endtask

  initial begin
    RESET = 1; BUSYWAIT = 0; OUT1 = 0; OUT2 = 0; INSTRUCTION = ins(8'hFF, 0, 0, 0);
    #1;
    clk_step(0);
    chk("reset_pc", PC, 32'h0);
    RESET = 0;
    for (int i = 1; i <= 3; i++) begin
      clk_step(0);
      chk("nop_pc", PC, 32'(4 * i));
    end

    vecs.push_back('{8'h00, 8'h03, 8'h05, 8'hAA, 8'h33, 8'h05, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{8'h01, 8'h01, 8'h02, 8'h11, 8'h3C, 8'h3C, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{8'h02, 8'h02, 8'h00, 8'h70, 8'h95, 8'h05, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{8'h02, 8'h02, 8'h00, 8'hFF, 8'h01, 8'h00, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{8'h03, 8'h04, 8'h01, 8'h03, 8'h05, 8'hFE, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{8'h03, 8'h04, 8'h01, 8'h05, 8'h05, 8'h00, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{8'h04, 8'h05, 8'h02, 8'hF0, 8'h3C, 8'h30, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{8'h05, 8'h06, 8'h02, 8'hF0, 8'h0C, 8'hFC, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{8'h09, 8'h07, 8'h03, 8'h00, 8'h42, 8'h42, 1, 0, 1, 1, 1, 0});
    vecs.push_back('{8'h0A, 8'h01, 8'h80, 8'h55, 8'h66, 8'h80, 1, 0, 1, 1, 1, 0});
    vecs.push_back('{8'h0B, 8'h00, 8'h04, 8'h99, 8'h07, 8'h07, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{8'h0C, 8'h00, 8'h00, 8'h99, 8'h77, 8'h00, 1, 1, 0, 0, 0, 1});
    vecs.push_back('{8'h07, 8'h05, 8'h02, 8'h01, 8'h02, 8'hFF, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{8'h08, 8'h01, 8'h02, 8'h05, 8'h03, 8'h02, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{8'h0E, 8'h02, 8'h01, 8'h12, 8'h34, 8'h00, 0, 0, 0, 0, 0, 0});
`ifdef EXEC_MULT_EN
    vecs.push_back('{8'h0D, 8'h02, 8'h01, 8'h13, 8'h11, 8'h43, 1, 0, 1, 0, 0, 0});
`else
    vecs.push_back('{8'h0D, 8'h02, 8'h01, 8'h13, 8'h11, 8'h00, 0, 0, 0, 0, 0, 0});
`endif

    foreach (vecs[i]) begin
      INSTRUCTION = ins(vecs[i].op, vecs[i].hi, 3'(i), vecs[i].lo);
      OUT1 = vecs[i].a;
      OUT2 = vecs[i].b;
      #1;
      if (vecs[i].alu_ok) begin
        chk($sformatf("v%0d_alu", i), 32'(ALU_RESULT), 32'(vecs[i].res));
        chk($sformatf("v%0d_zero", i), 32'(ZERO), 32'(vecs[i].z));
      end
      chk($sformatf("v%0d_ctl", i), {28'h0, REG_WRITE, WB_SEL, READEN, WRITEEN},
          {28'h0, vecs[i].rw, vecs[i].wb, vecs[i].rd, vecs[i].wr});
      chk($sformatf("v%0d_addr", i), {23'h0, RD_ADDR1, RD_ADDR2, WR_ADDR},
          {23'h0, 3'(i), vecs[i].lo[2:0], vecs[i].hi[2:0]});
      clk_step(vecs[i].op == 8'h06 || (vecs[i].op == 8'h07 && vecs[i].z) ||
               (vecs[i].op == 8'h08 && !vecs[i].z));
    end

    // beq/bne at PC 0x10 with equal operands
    RESET = 1; INSTRUCTION = ins(8'hFF, 0, 0, 0);
    clk_step(0);
    RESET = 0;
    repeat (4) clk_step(0);
    chk("pc_at_10", PC, 32'h10);
    INSTRUCTION = ins(8'h07, 8'h02, 3'd1, 8'h02); OUT1 = 8'h07; OUT2 = 8'h07;
    #1 chk("beq_zero", 32'(ZERO), 1);
    clk_step(1);
    chk("beq_pc", PC, 32'h1C);
    RESET = 1; INSTRUCTION = ins(8'hFF, 0, 0, 0);
    clk_step(0);
    RESET = 0;
    repeat (4) clk_step(0);
    INSTRUCTION = ins(8'h08, 8'h02, 3'd1, 8'h02);
    #1;
    clk_step(0);
    chk("bne_pc", PC, 32'h14);

    // backward jumps
    INSTRUCTION = ins(8'hFF, 0, 0, 0);
    repeat (3) clk_step(0);
    chk("pc_at_20", PC, 32'h20);
    INSTRUCTION = ins(8'h06, 8'hFE, 0, 0);
    clk_step(1);
    chk("j_back_pc", PC, 32'h1C);
    INSTRUCTION = ins(8'h06, 8'hFF, 0, 0);
    clk_step(1);
    chk("j_self_pc", PC, 32'h1C);

    // load stall
    INSTRUCTION = ins(8'h09, 8'h03, 3'd2, 8'h04); OUT1 = 8'h00; OUT2 = 8'h10; BUSYWAIT = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_regw", 32'(REG_WRITE), 0);
      chk("stall_rden", 32'(READEN), 1);
      clk_step(0);
      chk("stall_pc", PC, 32'h1C);
    end
    BUSYWAIT = 0;
    #1 chk("lwd_ctl", {29'h0, REG_WRITE, READEN, WB_SEL}, 32'h7);
    clk_step(0);
    chk("lwd_pc", PC, 32'h20);

    // reset while stalled
    BUSYWAIT = 1; RESET = 1;
    clk_step(0);
    chk("rst_stall_pc", PC, 32'h0);
    RESET = 0; BUSYWAIT = 0;
    INSTRUCTION = ins(8'hFF, 0, 0, 0);
    clk_step(0);
    chk("post_rst_pc", PC, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
